// File: rtl/sobel_pkg.sv
// Shared types and width helpers for the streaming Sobel filter.
// Gradients need three guard bits over the pixel width; the L1 sum needs four.
package sobel_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_L1     = 2'b00,
        MODE_GX     = 2'b01,
        MODE_GY     = 2'b10,
        MODE_THRESH = 2'b11
    } mode_e;

    localparam int GRAD_EXTRA = 3;
    localparam int SUM_EXTRA  = 4;

    function automatic int grad_width(input int pixel_width);
        return pixel_width + GRAD_EXTRA;
    endfunction

    function automatic int sum_width(input int pixel_width);
        return pixel_width + SUM_EXTRA;
    endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// FIFO handshakes plus per-frame controls of the Sobel stage.
// master = the filter, slave = the FIFOs and frame controller around it.
interface sobel_stream_if
    import sobel_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8
);
    logic                                in_rd_en;
    logic                                in_empty;
    logic [PIXEL_WIDTH-1:0]              in_dout;
    logic                                out_wr_en;
    logic                                out_full;
    logic [PIXEL_WIDTH-1:0]              out_din;
    logic [1:0]                          mode;
    logic [grad_width(PIXEL_WIDTH)-1:0]  threshold;
    logic                                done;

    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_wr_en,
        input  out_full,
        output out_din,
        input  mode,
        input  threshold,
        output done
    );

    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_wr_en,
        output out_full,
        input  out_din,
        output mode,
        output threshold,
        input  done
    );
endinterface

// File: rtl/sobel_window.sv
// Two-row-plus-two line buffer feeding a 3x3 neighbourhood; the live input pixel
// is the bottom-right tap, so the stored depth is exactly 2*W+2.
module sobel_window #(
    parameter int IMG_WIDTH   = 540,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   shift_en,
    input  logic [PIXEL_WIDTH-1:0] in_dout,
    output logic [PIXEL_WIDTH-1:0] win [3][3]
);
    localparam int DEPTH = 2 * IMG_WIDTH + 2;

    // Contents need no reset: every tap read for a non-border centre is refilled first.
    logic [PIXEL_WIDTH-1:0] line_reg [DEPTH];

    always_ff @(posedge clock) begin
        if (shift_en) begin
            line_reg[0] <= in_dout;
            for (int k = 1; k < DEPTH; k++) begin
                line_reg[k] <= line_reg[k-1];
            end
        end
    end

    // Entry k holds the pixel accepted k+1 pixels before the current input.
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_col
            if (gi == 2 && gj == 2) begin : g_live
                assign win[gi][gj] = in_dout;
            end else begin : g_stored
                assign win[gi][gj] = line_reg[(2 - gi) * IMG_WIDTH + (2 - gj) - 1];
            end
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter: one output per input pixel, border forced to zero,
// mode and threshold sampled on the first pixel of every frame.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH   = 540,
    parameter int IMG_HEIGHT  = 720,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    sobel_stream_if.master bus
);
    localparam int W     = IMG_WIDTH;
    localparam int H     = IMG_HEIGHT;
    localparam int PW    = PIXEL_WIDTH;
    localparam int GW    = grad_width(PW);
    localparam int SW    = sum_width(PW);
    localparam int N     = W * H;
    localparam int CNT_W = $clog2(N + 1);
    localparam int ROW_W = $clog2(H);
    localparam int COL_W = $clog2(W);

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(W);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(N - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(H - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(W - 1);
    localparam logic [SW-1:0]    SUM_MAX   = SW'((1 << PW) - 1);
    localparam logic [GW-1:0]    GRAD_MAX  = GW'((1 << PW) - 1);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] in_cnt_reg;
    logic [ROW_W-1:0] out_row_reg;
    logic [COL_W-1:0] out_col_reg;
    mode_e            mode_reg;
    logic [GW-1:0]    thresh_reg;
    logic             done_reg;

    logic             accept;
    logic             write;
    logic             border;
    logic             last_out;
    logic             frame_end;
    logic [PW-1:0]    pix_out;
    logic [PW-1:0]    result;
    logic [PW-1:0]    win [3][3];

    sobel_window #(
        .IMG_WIDTH   (W),
        .PIXEL_WIDTH (PW)
    ) u_window (
        .clock    (clock),
        .shift_en (accept),
        .in_dout  (bus.in_dout),
        .win      (win)
    );

    // Border comes from explicit output row/col counters so no divider is needed.
    assign border    = (out_row_reg == '0) || (out_row_reg == ROW_LAST) ||
                       (out_col_reg == '0) || (out_col_reg == COL_LAST);
    assign last_out  = (out_row_reg == ROW_LAST) && (out_col_reg == COL_LAST);
    assign frame_end = (state_reg == DRAIN) && write && last_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            FILL:    if (accept && in_cnt_reg == FILL_LAST) state_next = RUN;
            RUN:     if (accept && in_cnt_reg == RUN_LAST)  state_next = DRAIN;
            DRAIN:   if (frame_end)                         state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Handshakes are combinational and held low while reset is asserted.
    always_comb begin
        accept  = 1'b0;
        write   = 1'b0;
        pix_out = '0;
        if (reset_n) begin
            unique case (state_reg)
                FILL: accept = !bus.in_empty && !bus.out_full;
                RUN: begin
                    accept = !bus.in_empty && !bus.out_full;
                    write  = accept;
                    if (accept && !border) pix_out = result;
                end
                DRAIN:   write = !bus.out_full;
                default: ;
            endcase
        end
    end

    assign bus.in_rd_en  = accept;
    assign bus.out_wr_en = write;
    assign bus.out_din   = pix_out;
    assign bus.done      = done_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_cnt_reg  <= '0;
            out_row_reg <= '0;
            out_col_reg <= '0;
            mode_reg    <= MODE_L1;
            thresh_reg  <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= frame_end;
            if (frame_end) begin
                in_cnt_reg  <= '0;
                out_row_reg <= '0;
                out_col_reg <= '0;
            end else begin
                if (accept) begin
                    in_cnt_reg <= in_cnt_reg + CNT_W'(1);
                end
                if (accept && in_cnt_reg == '0) begin
                    mode_reg   <= mode_e'(bus.mode);
                    thresh_reg <= bus.threshold;
                end
                if (write) begin
                    if (out_col_reg == COL_LAST) begin
                        out_col_reg <= '0;
                        out_row_reg <= out_row_reg + ROW_W'(1);
                    end else begin
                        out_col_reg <= out_col_reg + COL_W'(1);
                    end
                end
            end
        end
    end

    // Positive and negative halves of each kernel are summed unsigned, then differenced.
    logic [PW+1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        gx_abs, gy_abs;
    logic [SW-1:0]        s_sum;

    assign gx_pos = {2'b00, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b00, win[2][2]};
    assign gx_neg = {2'b00, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b00, win[2][0]};
    assign gy_pos = {2'b00, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b00, win[2][2]};
    assign gy_neg = {2'b00, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b00, win[0][2]};

    assign gx     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    assign gy     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    assign gx_abs = gx[GW-1] ? -gx : gx;
    assign gy_abs = gy[GW-1] ? -gy : gy;
    assign s_sum  = {1'b0, gx_abs} + {1'b0, gy_abs};

    always_comb begin
        result = '0;
        unique case (mode_reg)
            MODE_L1:     result = (s_sum  > SUM_MAX)  ? '1 : s_sum[PW-1:0];
            MODE_GX:     result = (gx_abs > GRAD_MAX) ? '1 : gx_abs[PW-1:0];
            MODE_GY:     result = (gy_abs > GRAD_MAX) ? '1 : gy_abs[PW-1:0];
            MODE_THRESH: result = (s_sum > {1'b0, thresh_reg}) ? '1 : '0;
        endcase
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Drives an 8-bit and a 10-bit filter in lockstep (10-bit pixels are the 8-bit ones x4)
// and checks every output pixel, done timing and stall behaviour.
module tb_sobel_stream;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sobel_stream_if #(.PIXEL_WIDTH(8))  if_a ();
    sobel_stream_if #(.PIXEL_WIDTH(10)) if_b ();

    sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if_a)
    );

    sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(10)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if_b)
    );

    typedef struct {
        string      name;
        int         pat;
        int         md;
        int         thr;
        logic [7:0] mask;   // interior columns expected to be non-zero
        int         v8;
        int         v10;
    } vec_t;

    vec_t vecs[8];
    int   fr[N];
    int   exp_a[N];
    int   exp_b[N];
    int   got_a[$];
    int   got_b[$];
    int   cyc_cnt = 0;
    int   last_wr_cyc, done_cyc, done_cnt_a, done_cnt_b;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc_cnt++;

    always @(negedge clock) begin
        if (if_a.out_wr_en) begin
            got_a.push_back(int'(if_a.out_din));
            last_wr_cyc = cyc_cnt;
        end
        if (if_b.out_wr_en) got_b.push_back(int'(if_b.out_din));
        if (if_a.done) begin
            done_cnt_a++;
            done_cyc = cyc_cnt;
        end
        if (if_b.done) done_cnt_b++;
    end

    function automatic void check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    task automatic set_in(input bit empty, input bit full, input int pix, input int md, input int thr);
        if_a.in_empty  = empty;      if_b.in_empty  = empty;
        if_a.out_full  = full;       if_b.out_full  = full;
        if_a.in_dout   = 8'(pix);    if_b.in_dout   = 10'(pix * 4);
        if_a.mode      = 2'(md);     if_b.mode      = 2'(md);
        if_a.threshold = 11'(thr);   if_b.threshold = 13'(thr * 4);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        set_in(1'b0, 1'b0, 0, 0, 0);
        @(negedge clock);
        check("rst_rd_en_a",  int'(if_a.in_rd_en),  0);
        check("rst_wr_en_a",  int'(if_a.out_wr_en), 0);
        check("rst_out_din_a", int'(if_a.out_din),  0);
        check("rst_done_a",   int'(if_a.done),      0);
        check("rst_rd_en_b",  int'(if_b.in_rd_en),  0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        set_in(1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic build(input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (pat)
                    0:       fr[r*W+c] = 100;
                    1:       fr[r*W+c] = (c >= 4) ? 200 : 0;
                    2:       fr[r*W+c] = 10 * c;
                    3:       fr[r*W+c] = 50;
                    default: fr[r*W+c] = int'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    function automatic int px(input int r, input int c, input int scale);
        return fr[r*W+c] * scale;
    endfunction

    function automatic int model(input int r, input int c, input int scale,
                                 input int md, input int thr, input int pw);
        int gx, gy, ax, ay, s, mx;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
        gx = (px(r-1,c+1,scale) + 2*px(r,c+1,scale) + px(r+1,c+1,scale))
           - (px(r-1,c-1,scale) + 2*px(r,c-1,scale) + px(r+1,c-1,scale));
        gy = (px(r+1,c-1,scale) + 2*px(r+1,c,scale) + px(r+1,c+1,scale))
           - (px(r-1,c-1,scale) + 2*px(r-1,c,scale) + px(r-1,c+1,scale));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        s  = ax + ay;
        mx = (1 << pw) - 1;
        case (md)
            0:       return (s  > mx) ? mx : s;
            1:       return (ax > mx) ? mx : ax;
            2:       return (ay > mx) ? mx : ay;
            default: return (s > thr) ? mx : 0;
        endcase
    endfunction

    task automatic run_frame(input string name, input int md, input int thr,
                             input int full_at, input int empty_at, input int rst_at);
        int idx, full_left, empty_left, cyc, post;
        bit full_used, empty_used, stop;
        idx = 0; full_left = 0; empty_left = 0; cyc = 0; post = -1;
        full_used = 0; empty_used = 0; stop = 0;
        got_a.delete(); got_b.delete();
        done_cnt_a = 0; done_cnt_b = 0; done_cyc = -1; last_wr_cyc = -1;
        while (!stop) begin
            @(posedge clock);
            #1;
            if (!full_used && idx == full_at) begin full_used = 1; full_left = 5; end
            if (!empty_used && idx == empty_at) begin empty_used = 1; empty_left = 3; end
            if (idx == rst_at) begin
                apply_reset();
                return;
            end
            // Mode and threshold are only valid for the first pixel; afterwards they are scrambled.
            set_in((empty_left > 0) || (idx >= N), full_left > 0, (idx < N) ? fr[idx] : 0,
                   (idx == 0) ? md : (md ^ 3), (idx == 0) ? thr : 0);
            @(negedge clock);
            if (full_left > 0 || empty_left > 0) begin
                check({name, "_stall_rd"}, int'(if_a.in_rd_en),  0);
                check({name, "_stall_wr"}, int'(if_a.out_wr_en), 0);
            end
            check({name, "_rd_sync"}, int'(if_b.in_rd_en), int'(if_a.in_rd_en));
            if (if_a.in_rd_en) idx++;
            if (full_left > 0)  full_left--;
            if (empty_left > 0) empty_left--;
            if (post < 0 && if_a.done) post = 2;
            else if (post > 0) begin
                post--;
                if (post == 0) stop = 1;
            end
            cyc++;
            if (!stop && cyc > 400) begin
                check({name, "_timeout"}, cyc, 400);
                stop = 1;
            end
        end
    endtask

    task automatic verify_frame(input string name);
        check({name, "_count_a"}, got_a.size(), N);
        check({name, "_count_b"}, got_b.size(), N);
        check({name, "_done_a"},  done_cnt_a, 1);
        check({name, "_done_b"},  done_cnt_b, 1);
        check({name, "_done_gap"}, done_cyc - last_wr_cyc, 1);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_a[%0d]", name, k), (k < got_a.size()) ? got_a[k] : -1, exp_a[k]);
            check($sformatf("%s_b[%0d]", name, k), (k < got_b.size()) ? got_b[k] : -1, exp_b[k]);
        end
        $display("frame %s: outputs=%0d/%0d done=%0d/%0d", name, got_a.size(), got_b.size(),
                 done_cnt_a, done_cnt_b);
    endtask

    task automatic set_exp_model(input int md, input int thr);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                exp_a[r*W+c] = model(r, c, 1, md, thr, 8);
                exp_b[r*W+c] = model(r, c, 4, md, thr * 4, 10);
            end
        end
    endtask

    initial begin
        vecs[0] = '{"const_l1",   0, 0,  0, 8'h00, 0,   0};
        vecs[1] = '{"step_l1",    1, 0,  0, 8'h18, 255, 1023};
        vecs[2] = '{"step_gy",    1, 2,  0, 8'h00, 0,   0};
        vecs[3] = '{"step_gx",    1, 1,  0, 8'h18, 255, 1023};
        vecs[4] = '{"ramp_thr79", 2, 3, 79, 8'hFF, 255, 1023};
        vecs[5] = '{"ramp_thr80", 2, 3, 80, 8'h00, 0,   0};
        vecs[6] = '{"ramp_l1",    2, 0,  0, 8'hFF, 80,  320};
        vecs[7] = '{"ramp_gy",    2, 2,  0, 8'h00, 0,   0};

        apply_reset();

        for (int v = 0; v < 8; v++) begin
            build(vecs[v].pat);
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    if (r == 0 || r == H-1 || c == 0 || c == W-1 || !vecs[v].mask[c]) begin
                        exp_a[r*W+c] = 0;
                        exp_b[r*W+c] = 0;
                    end else begin
                        exp_a[r*W+c] = vecs[v].v8;
                        exp_b[r*W+c] = vecs[v].v10;
                    end
                end
            end
            run_frame(vecs[v].name, vecs[v].md, vecs[v].thr, -1, -1, -1);
            verify_frame(vecs[v].name);
        end

        build(4);
        set_exp_model(0, 0);
        run_frame("rand_stall", 0, 0, 20, 30, -1);
        verify_frame("rand_stall");

        build(4);
        set_exp_model(3, 300);
        run_frame("rand_thr", 3, 300, -1, -1, -1);
        verify_frame("rand_thr");

        build(3);
        run_frame("rst_mid", 0, 0, -1, -1, 25);
        $display("frame rst_mid: abandoned at i=25");
        for (int k = 0; k < N; k++) begin
            exp_a[k] = 0;
            exp_b[k] = 0;
        end
        run_frame("const50", 0, 0, -1, -1, -1);
        verify_frame("const50");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
